// File: rtl/tpg_pkg.sv
// Shared types and helpers for the LFSR test-pattern generator and related BIST blocks.
// Default taps are primitive for the shift-left Fibonacci form used by tpg_lfsr_step.
package tpg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int MAX_WIDTH = 16;

  // Bit i set means state[i] feeds the XOR; MSB is always part of the polynomial.
  function automatic logic [MAX_WIDTH-1:0] default_taps(input int width);
    case (width)
      2:       return 16'h0003;
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic int unsigned total_patterns(input int width, input logic zmode);
    return (32'd1 << width) - (zmode ? 32'd0 : 32'd1);
  endfunction

endpackage

// File: rtl/tpg_lfsr_param_if.sv
// Pattern stream and run-control bundle between the TPG and its BIST controller / CUT side.
interface tpg_lfsr_param_if #(
  parameter int WIDTH = 3
);

  logic             start;
  logic [WIDTH-1:0] seed;
  logic             include_zero;
  logic             ready;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic [WIDTH-1:0] pattern_index;
  logic             busy;
  logic             complete;

  modport master (
    input  start, seed, include_zero, ready,
    output data_out, data_valid, pattern_index, busy, complete
  );

  modport slave (
    output start, seed, include_zero, ready,
    input  data_out, data_valid, pattern_index, busy, complete
  );

endinterface

// File: rtl/tpg_lfsr_step.sv
// Combinational next-state of a Fibonacci LFSR, optionally splicing the all-zero state
// between 10..0 and 00..01 so the cycle covers every WIDTH-bit value.
module tpg_lfsr_step #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] taps,
  input  logic             zmode,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = {cur[WIDTH-2:0], ^(cur & taps)};
    if (zmode) begin
      if (cur == {1'b1, {(WIDTH-1){1'b0}}}) begin
        nxt = '0;
      end else if (cur == '0) begin
        nxt = WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/tpg_lfsr_param.sv
// Parametrised LFSR test-pattern generator: first pattern is valid right after the accepted start,
// holds data while ready is low, and advances one pattern per accepted handshake with no bubbles.
module tpg_lfsr_param
  import tpg_pkg::*;
#(
  parameter int               WIDTH = 3,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH))
) (
  input  logic                  clock,
  input  logic                  reset,
  tpg_lfsr_param_if.master      bus
);

  state_t           state;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] lfsr_nxt;
  logic [WIDTH-1:0] seed_eff;
  logic [WIDTH:0]   count;
  logic [WIDTH:0]   last_idx;
  logic             zmode;

  tpg_lfsr_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .cur   (lfsr),
    .taps  (TAPS),
    .zmode (zmode),
    .nxt   (lfsr_nxt)
  );

  // The pure LFSR locks up on zero, so an all-zero seed becomes 00..01.
  assign seed_eff = (bus.seed == '0 && !bus.include_zero) ? WIDTH'(1) : bus.seed;
  assign last_idx = (WIDTH+1)'(total_patterns(WIDTH, zmode) - 32'd1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      lfsr  <= '0;
      count <= '0;
      zmode <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            lfsr  <= seed_eff;
            count <= '0;
            zmode <= bus.include_zero;
            state <= RUN;
          end
        end
        RUN: begin
          if (bus.ready) begin
            // The last pattern stays on data_out after completion.
            if (count == last_idx) begin
              state <= DONE;
            end else begin
              lfsr  <= lfsr_nxt;
              count <= count + (WIDTH+1)'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_out      = lfsr;
  assign bus.data_valid    = (state == RUN);
  assign bus.busy          = (state == RUN);
  assign bus.complete      = (state == DONE);
  assign bus.pattern_index = count[WIDTH-1:0];

endmodule

// File: doc/tpg_lfsr_param.md
Name: tpg_lfsr_param

Overview:
Parametrised test-pattern generator for the BIST datapath. It succeeds the fixed 3-bit LFSR TPG.
- Produces a maximal-length Fibonacci LFSR sequence of WIDTH bits from a runtime seed.
- Can optionally insert the all-zero pattern, giving exhaustive 2^WIDTH coverage.
- Paces output with a valid/ready handshake toward the CUT/ORA, and flags completion for the BIST controller.

Parameters:
- WIDTH, 3, pattern width in bits (2..16).
- TAPS, 3'b110, WIDTH-bit feedback mask. Bit i set means state[i] is XORed into feedback. TAPS[WIDTH-1] must be 1, and the polynomial must be primitive.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle request to begin a run. Sampled in IDLE or DONE only.
- seed, input, WIDTH, initial pattern. Sampled on the accepted start.
- include_zero, input, 1, insert the all-zero pattern. Sampled on the accepted start.
- ready, input, 1, consumer accepts data_out this cycle.
- data_out, output, WIDTH, current pattern.
- data_valid, output, 1, data_out holds a pattern to be consumed.
- pattern_index, output, WIDTH, zero-based index of the current pattern.
- busy, output, 1, high in RUN.
- complete, output, 1, high in DONE.

Behaviour:
- Reset: synchronous, active-high, single clock domain. On reset, state returns to IDLE and all outputs, internal count and LFSR register clear to 0 on the next edge. This applies from any state, including mid-run.
- FSM states and transitions:
  - IDLE, start=1: load lfsr from seed, clear count, latch include_zero into zmode, go to RUN.
  - RUN, data_valid & ready & (count == total-1): go to DONE.
  - DONE, start=1: same as from IDLE, and complete clears on that edge. Otherwise hold DONE.
- start while in RUN is ignored.
- Seed substitution: if seed==0 and include_zero==0, load 00..01 instead. An all-zero seed is illegal for the pure LFSR.
- total = 2^WIDTH-1 when zmode=0; total = 2^WIDTH when zmode=1. The internal count is WIDTH+1 bits.
- Latency: start accepted at edge k puts the first pattern (the loaded value) on data_out with data_valid=1 immediately after edge k.
- Handshake:
  - data_out and pattern_index are held stable while data_valid & !ready.
  - On data_valid & ready, lfsr advances and count increments at that edge.
  - No bubbles are inserted: data_valid stays high through RUN.
- Normal next state: {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}.
- Zero insertion (zmode=1):
  - If lfsr == 10..0, next = 00..0.
  - If lfsr == 00..0, next = 00..01.
  - Otherwise use the normal next state.
- Completion: when the last pattern is accepted at edge m, after edge m data_valid=0, busy=0, complete=1. data_out and pattern_index keep their last values until the next start or reset.
- Output decode: busy = (state==RUN); complete = (state==DONE); pattern_index = count[WIDTH-1:0].

Decomposition:
- Package tpg_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - a default primitive tap-mask function per width (2..16);
  - a localparam helper for total-pattern computation.
- One combinational sub-module, tpg_lfsr_step, maps (state, taps, zmode) to next state. It is reusable by the future MISR/ORA block.

Test Plan:
1. WIDTH=3, TAPS=110, seed=001, include_zero=0, ready=1, pulse start:
   - data_out 001,010,101,011,111,110,100 on 7 consecutive cycles;
   - pattern_index 0..6;
   - then data_valid=0, complete=1, busy=0.
2. Same as 1 but include_zero=1:
   - 8 patterns 001,010,101,011,111,110,100,000;
   - pattern_index 0..7, then complete=1.
3. Scenario 1 with ready=0 for 3 cycles while data_out=101:
   - data_out holds 101 and pattern_index holds 2 for those cycles;
   - the sequence resumes 011 after ready returns, and completion is delayed by exactly 3 cycles.
4. seed=000, include_zero=0:
   - first pattern is 001 and the full 7-pattern sequence follows.
   - seed=000, include_zero=1: sequence starts 000,001,010 and produces 8 patterns.
5. reset=1 for one cycle while pattern_index=4:
   - next cycle all outputs are 0 and the FSM is in IDLE;
   - a following start with seed=011 restarts at 011, index 0.
6. start pulses during RUN change nothing. In DONE, start with seed=111:
   - complete clears at the same edge;
   - data_out=111, data_valid=1, and a fresh 7-pattern run follows.
